// File: rtl/shift_normalizer_pkg.sv
// Shared datapath package: normalizer widths, FSM state encoding and the shift-op codes
// also used by the combinational shifter.
package shift_pkg;

    localparam int SN_WIDTH = 16;
    localparam int SN_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SHOP_SLL = 2'd0;
    localparam logic [1:0] SHOP_SRL = 2'd1;
    localparam logic [1:0] SHOP_SRA = 2'd2;

endpackage

// File: rtl/shift_normalizer_if.sv
// Start/done handshake bundle for the normalizer; master drives requests, slave is the block.
interface shift_normalizer_if #(
    parameter int WIDTH = shift_pkg::SN_WIDTH,
    parameter int CNT_W = shift_pkg::SN_CNT_W
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] opA;
    logic             signedMode;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] normOut;
    logic [CNT_W-1:0] shiftCnt;
    logic             zeroFlag;

    modport master (
        output start_valid, opA, signedMode, done_ready,
        input  start_ready, done_valid, normOut, shiftCnt, zeroFlag
    );

    modport slave (
        input  start_valid, opA, signedMode, done_ready,
        output start_ready, done_valid, normOut, shiftCnt, zeroFlag
    );
endinterface

// File: rtl/shift_normalizer_norm_detect.sv
// Combinational stop test for the normalizer. Signed compare exists only with SIGNED_NORM_EN.
module norm_detect
    import shift_pkg::*;
#(
    parameter int WIDTH = SN_WIDTH
) (
    input  logic [WIDTH-1:0] i_work,
    input  logic             i_signed,
    output logic             o_is_norm,
    output logic             o_is_zero
);

    assign o_is_zero = (i_work == '0);

`ifdef SIGNED_NORM_EN
    // Signed operands are normalized once the sign bit differs from the next bit.
    assign o_is_norm = i_signed ? (i_work[WIDTH-1] ^ i_work[WIDTH-2]) : i_work[WIDTH-1];
`else
    logic w_unused_signed;
    assign w_unused_signed = i_signed;
    assign o_is_norm       = i_work[WIDTH-1];
`endif

endmodule

// File: rtl/shift_normalizer.sv
// Iterative left-normalizer: one shift per cycle until normalized or saturated.
// Optional signed normalization via SIGNED_NORM_EN.
module shift_normalizer
    import shift_pkg::*;
#(
    parameter int WIDTH = SN_WIDTH,
    parameter int CNT_W = SN_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    shift_normalizer_if.slave  bus
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_work;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_norm;
    logic [CNT_W-1:0] r_cnt;
    logic             r_zero;
    logic             w_mode;
    logic             w_is_norm;
    logic             w_is_zero;
    logic             w_sat;

`ifdef SIGNED_NORM_EN
    logic r_signed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_signed <= 1'b0;
        end else if (r_state == IDLE && bus.start_valid) begin
            r_signed <= bus.signedMode;
        end
    end

    assign w_mode = r_signed;
`else
    logic w_unused_mode;
    assign w_unused_mode = bus.signedMode;
    assign w_mode        = 1'b0;
`endif

    norm_detect #(.WIDTH(WIDTH)) u_detect (
        .i_work    (r_work),
        .i_signed  (w_mode),
        .o_is_norm (w_is_norm),
        .o_is_zero (w_is_zero)
    );

    assign w_sat = (r_count == CNT_W'(WIDTH - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start_valid) w_next = RUN;
            RUN:     if (w_is_zero || w_is_norm || w_sat) w_next = DONE;
            DONE:    if (bus.done_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_work  <= '0;
            r_count <= '0;
            r_norm  <= '0;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start_valid) begin
                        r_work  <= bus.opA;
                        r_count <= '0;
                    end
                end
                RUN: begin
                    // Stop test precedes the shift, so the result is the pre-shift work value.
                    if (w_is_zero) begin
                        r_norm <= '0;
                        r_cnt  <= '0;
                        r_zero <= 1'b1;
                    end else if (w_is_norm || w_sat) begin
                        r_norm <= r_work;
                        r_cnt  <= r_count;
                        r_zero <= 1'b0;
                    end else begin
                        r_work  <= {r_work[WIDTH-2:0], 1'b0};
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.start_ready = (r_state == IDLE);
    assign bus.done_valid  = (r_state == DONE);
    assign bus.normOut     = r_norm;
    assign bus.shiftCnt    = r_cnt;
    assign bus.zeroFlag    = r_zero;

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed self-checking bench for shift_normalizer; signed vectors active under SIGNED_NORM_EN.
module tb_shift_normalizer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    shift_normalizer_if #(.WIDTH(16), .CNT_W(4)) bus ();

    shift_normalizer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_op(input logic [15:0] op, input logic mode);
        bus.opA         = op;
        bus.signedMode  = mode;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.start_valid = 1'b0;
        bus.opA         = '0;
        bus.signedMode  = 1'b0;
        bus.done_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.done_valid !== 1'b0 || bus.normOut !== 16'h0000 ||
            bus.shiftCnt !== 4'd0 || bus.zeroFlag !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b dv=%b norm=%h cnt=%0d zf=%b, required rdy=1 dv=0 norm=0000 cnt=0 zf=0",
                     bus.start_ready, bus.done_valid, bus.normOut, bus.shiftCnt, bus.zeroFlag);
        end
    endtask

    task automatic test_vector(input string name, input logic [15:0] op, input logic mode,
                               input logic [15:0] exp_norm, input logic [3:0] exp_cnt,
                               input logic exp_zero, input int exp_lat);
        int cyc;
        start_op(op, mode);
        checks++;
        if (bus.start_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: start_ready=%b, required 0", name, bus.start_ready);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d, required %0d", name, cyc, exp_lat);
        end
        checks++;
        if (bus.normOut !== exp_norm || bus.shiftCnt !== exp_cnt || bus.zeroFlag !== exp_zero) begin
            errors++;
            $display("FAIL %s result: norm=%h cnt=%0d zf=%b, required norm=%h cnt=%0d zf=%b",
                     name, bus.normOut, bus.shiftCnt, bus.zeroFlag, exp_norm, exp_cnt, exp_zero);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s return: dv=%b rdy=%b, required dv=0 rdy=1",
                     name, bus.done_valid, bus.start_ready);
        end
    endtask

    task automatic test_unsigned();
        test_vector("u_0001", 16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0, 16);
        test_vector("u_8000", 16'h8000, 1'b0, 16'h8000, 4'd0,  1'b0, 1);
        test_vector("u_zero", 16'h0000, 1'b0, 16'h0000, 4'd0,  1'b1, 1);
        test_vector("u_0123", 16'h0123, 1'b0, 16'h9180, 4'd7,  1'b0, 8);
    endtask

    task automatic test_backpressure();
        int cyc;
        bus.done_ready  = 1'b0;
        bus.opA         = 16'h00F0;
        bus.signedMode  = 1'b0;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.opA = 16'h1234;
        checks++;
        if (bus.start_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp busy: start_ready=%b, required 0", bus.start_ready);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 9) begin
            errors++;
            $display("FAIL bp latency: got %0d, required 9", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.done_valid !== 1'b1 || bus.start_ready !== 1'b0 ||
                bus.normOut !== 16'hF000 || bus.shiftCnt !== 4'd8 || bus.zeroFlag !== 1'b0) begin
                errors++;
                $display("FAIL bp hold[%0d]: dv=%b rdy=%b norm=%h cnt=%0d zf=%b, required dv=1 rdy=0 norm=f000 cnt=8 zf=0",
                         i, bus.done_valid, bus.start_ready, bus.normOut, bus.shiftCnt, bus.zeroFlag);
            end
            @(posedge clk); #1;
        end
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.done_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp release: dv=%b rdy=%b, required dv=0 rdy=1", bus.done_valid, bus.start_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.done_valid !== 1'b0 || bus.normOut !== 16'hF000 || bus.shiftCnt !== 4'd8) begin
            errors++;
            $display("FAIL bp no_queue: dv=%b norm=%h cnt=%0d, required dv=0 norm=f000 cnt=8",
                     bus.done_valid, bus.normOut, bus.shiftCnt);
        end
    endtask

    task automatic test_reset_mid_run();
        start_op(16'h0001, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.done_valid !== 1'b0 || bus.normOut !== 16'h0000 ||
            bus.shiftCnt !== 4'd0 || bus.zeroFlag !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: rdy=%b dv=%b norm=%h cnt=%0d zf=%b, required rdy=1 dv=0 norm=0000 cnt=0 zf=0",
                     bus.start_ready, bus.done_valid, bus.normOut, bus.shiftCnt, bus.zeroFlag);
        end
        test_vector("after_rst", 16'h4000, 1'b0, 16'h8000, 4'd1, 1'b0, 2);
    endtask

    task automatic test_signed();
`ifdef SIGNED_NORM_EN
        test_vector("s_fff0", 16'hFFF0, 1'b1, 16'h8000, 4'd11, 1'b0, 12);
        test_vector("s_0003", 16'h0003, 1'b1, 16'h6000, 4'd13, 1'b0, 14);
        test_vector("s_ffff", 16'hFFFF, 1'b1, 16'h8000, 4'd15, 1'b0, 16);
        test_vector("s_zero", 16'h0000, 1'b1, 16'h0000, 4'd0,  1'b1, 1);
        test_vector("s_off",  16'h0003, 1'b0, 16'hC000, 4'd14, 1'b0, 15);
`else
        test_vector("s_ign_fff0", 16'hFFF0, 1'b1, 16'hFFF0, 4'd0,  1'b0, 1);
        test_vector("s_ign_0003", 16'h0003, 1'b1, 16'hC000, 4'd14, 1'b0, 15);
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unsigned();
        test_backpressure();
        test_reset_mid_run();
        test_signed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_normalizer.md
Name: shift_normalizer

Overview:
- Iterative left-normalizer for the 16-bit datapath; the inverse partner of the combinational shifter.
- Takes an operand and shifts it left one bit per cycle until it is normalized.
- Returns the normalized value plus the shift count that, applied as a right shift, restores the operand.
- Sits beside the ALU/shifter; used by multi-cycle normalize/count-leading-zero instructions via a valid/ready handshake.

Parameters:
WIDTH, 16, operand/result width
CNT_W, 4, shift count width; max count = WIDTH-1

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start_valid  input  1  operand request valid
start_ready  output  1  block can accept an operand
opA  input  WIDTH  operand, sampled on start handshake
signedMode  input  1  signed normalization select, sampled on start handshake (ignored unless SIGNED_NORM_EN)
done_valid  output  1  result valid
done_ready  input  1  consumer accepts result
normOut  output  WIDTH  normalized value
shiftCnt  output  CNT_W  number of left shifts applied
zeroFlag  output  1  operand was zero

Behaviour:
- Reset (synchronous, active-high): state=IDLE; normOut=0, shiftCnt=0, zeroFlag=0, done_valid=0, start_ready=1. Reset wins over every other event, including mid-RUN and during DONE.
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid&&start_ready (cycle T):
  - latch opA into the work register, count=0, latch signedMode;
  - go to RUN.
- RUN (start_ready=0), evaluated each cycle; the stop test is checked before shifting:
  - zero operand: go to DONE with zeroFlag=1, normOut=0, shiftCnt=0;
  - normalized (unsigned: bit WIDTH-1 = 1): go to DONE;
  - count = WIDTH-1: go to DONE (saturation bound);
  - otherwise: work <<= 1 (zero fill), count += 1.
- Latency:
  - done_valid rises at cycle T+1+lz, where lz = leading zeros (0..15);
  - zero operand completes at T+1.
- DONE:
  - done_valid=1; normOut, shiftCnt and zeroFlag are held stable while done_ready=0;
  - on done_valid&&done_ready, return to IDLE next cycle with done_valid=0;
  - outputs keep their last values in IDLE.
- start_valid outside IDLE is ignored and not queued. There is no same-cycle DONE→accept bypass; minimum issue interval is lz+3 cycles.
- Invariant, nonzero operand: (normOut >> shiftCnt) == opA (logical).
- Count never wraps: it saturates at WIDTH-1 by construction.

Optional Feature:
- Macro: SIGNED_NORM_EN.
- Defined, with latched signedMode=1:
  - normalized means bit WIDTH-1 != bit WIDTH-2;
  - zero operand behaves as in unsigned mode;
  - 0xFFFF saturates to 0x8000 with shiftCnt=15;
  - invariant becomes (normOut >>> shiftCnt) == opA (arithmetic).
- Defined, with signedMode=0: unsigned behaviour.
- Undefined: signedMode port is present but ignored; always unsigned; no signed-compare logic is synthesized.

Decomposition:
- Shared package shift_pkg holds:
  - WIDTH default and CNT_W;
  - FSM state typedef (IDLE/RUN/DONE, 2-bit encoding);
  - shift-op localparams already shared with the shifter.
- One natural sub-module: norm_detect, combinational. Inputs: work value and mode. Outputs: is_norm and is_zero. It isolates the unsigned/signed stop test, including the SIGNED_NORM_EN gating.

Test Plan:
1. opA=0x0001, unsigned → normOut=0x8000, shiftCnt=15, zeroFlag=0; done_valid at T+16.
2. opA=0x8000 → normOut=0x8000, shiftCnt=0; done_valid at T+1.
3. opA=0x0000 → normOut=0x0000, shiftCnt=0, zeroFlag=1; done_valid at T+1.
4. opA=0x00F0, done_ready=0 for 5 cycles, start_valid held high with opA=0x1234 throughout:
   - result is normOut=0xF000, shiftCnt=8, stable for all 5 cycles;
   - start_ready=0 throughout and 0x1234 is not accepted;
   - after done_ready=1, IDLE next cycle.
5. opA=0x0001, assert reset at 3rd RUN cycle → next cycle IDLE, all outputs 0, start_ready=1; fresh opA=0x4000 then yields 0x8000, shiftCnt=1.
6. SIGNED_NORM_EN defined, signedMode=1:
   - 0xFFF0 → 0x8000, shiftCnt=11;
   - 0x0003 → 0x6000, shiftCnt=13;
   - 0xFFFF → 0x8000, shiftCnt=15.
